gaussian_rd_ctrl: RTL and testbench

- Read-side sequencer for the gaussian accelerator.
- On start, walks one host buffer (base byte address and byte size, from the HC_BUFFER CSRs) and issues one CCI-P c0 cache-line read per cycle, throttled by almost-full and an outstanding-request cap.
- Counts responses, forwards each 512b line to the compute datapath tagged with its line index, and signals completion or abort to the top-level control FSM, which owns the DSM writeback.

---
 rtl/gaussian_pkg.sv | 27 ++
 rtl/gaussian_credit_cnt.sv | 45 ++++
 rtl/gaussian_rd_ctrl.sv | 164 ++++++++++++++++
 tb/tb_gaussian_rd_ctrl.sv | 369 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gaussian_pkg.sv
// Shared types and helpers for the gaussian accelerator read path.
package gaussian_pkg;

   typedef enum logic [1:0] {
      S_RD_IDLE,
      S_RD_FETCH,
      S_RD_DRAIN,
      S_RD_FINISH
   } t_rd_ctrl_state;

   typedef logic [41:0] t_line_addr;

   typedef struct packed {
      logic [63:0] addr;
      logic [31:0] size;
   } t_hc_buffer;

   localparam int RD_MAX_OUTSTANDING = 64;

   // Round the byte size up to whole 64B lines; 33b so a near-4GiB size cannot wrap.
   function automatic logic [32:0] hc_size_to_lines(input t_hc_buffer hc_i);
      logic [32:0] sum;
      sum = {1'b0, hc_i.size} + 33'd63;
      return sum >> 6;
   endfunction

endpackage

// File: rtl/gaussian_credit_cnt.sv
// Up/down in-flight counter: saturates at MAX, ignores decrements when empty,
// and holds when an increment and a decrement land in the same cycle.
module gaussian_credit_cnt #(
   parameter int MAX   = 64,
   parameter int CNT_W = $clog2(MAX) + 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr,
   input  logic             inc,
   input  logic             dec,
   output logic [CNT_W-1:0] count,
   output logic             at_cap,
   output logic             empty
);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             inc_ok, dec_ok;

   assign at_cap = (cnt_q == CNT_W'(MAX));
   assign empty  = (cnt_q == '0);
   assign count  = cnt_q;

   always_comb begin
      inc_ok = inc && !at_cap;
      dec_ok = dec && !empty;
      cnt_d  = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (inc_ok && !dec_ok) begin
         cnt_d = cnt_q + CNT_W'(1);
      end else if (dec_ok && !inc_ok) begin
         cnt_d = cnt_q - CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/gaussian_rd_ctrl.sv
// Read sequencer: walks one host buffer issuing c0 line reads under almfull and
// an in-flight cap, forwards responses tagged by line index, reports done/abort.
module gaussian_rd_ctrl
   import gaussian_pkg::*;
#(
   parameter int MAX_OUTSTANDING = RD_MAX_OUTSTANDING,
   parameter int LINES_W         = 27
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic               stop,
   input  logic [63:0]        buf_addr,
   input  logic [31:0]        buf_size,
   input  logic               tx_almfull,
   output logic               rd_req_valid,
   output logic [41:0]        rd_req_addr,
   output logic [15:0]        rd_req_mdata,
   input  logic               rd_rsp_valid,
   input  logic [15:0]        rd_rsp_mdata,
   input  logic [511:0]       rd_rsp_data,
   output logic               blk_valid,
   output logic [15:0]        blk_idx,
   output logic [511:0]       blk_data,
   output logic               busy,
   output logic               done,
   output logic               aborted,
   output logic [LINES_W:0]   lines_received
);

   localparam int CNT_W = $clog2(MAX_OUTSTANDING) + 1;
   localparam int LN_W  = LINES_W + 1;

   t_rd_ctrl_state   state_q, state_d;
   logic [LN_W-1:0]  num_lines_q, num_lines_d, issued_q, issued_d;
   logic [LN_W-1:0]  received_q, received_d, rcv_next;
   t_line_addr       base_q, base_d, req_addr_q, req_addr_d;
   logic [15:0]      req_mdata_q, req_mdata_d, blk_idx_q, blk_idx_d;
   logic [511:0]     blk_data_q, blk_data_d;
   logic             req_valid_q, req_valid_d, blk_valid_q, blk_valid_d;
   logic             done_q, done_d, aborted_q, aborted_d;
   logic             start_ok, issue_ok, rsp_ok, drain_done;
   logic [CNT_W-1:0] out_cnt;
   logic             out_at_cap, out_empty;
   t_hc_buffer       hc;

   gaussian_credit_cnt #(
      .MAX   (MAX_OUTSTANDING),
      .CNT_W (CNT_W)
   ) u_credit (
      .clk    (clk),
      .rst_n  (rst_n),
      .clr    (start_ok),
      .inc    (issue_ok),
      .dec    (rsp_ok),
      .count  (out_cnt),
      .at_cap (out_at_cap),
      .empty  (out_empty)
   );

   always_comb begin
      hc         = '{addr: buf_addr, size: buf_size};
      start_ok   = start && (state_q == S_RD_IDLE);
      issue_ok   = (state_q == S_RD_FETCH) && !tx_almfull && !out_at_cap &&
                   (issued_q < num_lines_q);
      // Responses with nothing in flight are strays from before a reset.
      rsp_ok     = rd_rsp_valid && (state_q != S_RD_IDLE) && !out_empty;
      rcv_next   = received_q + LN_W'(rsp_ok);
      drain_done = out_empty || (rsp_ok && (out_cnt == CNT_W'(1)));

      state_d     = state_q;
      num_lines_d = num_lines_q;
      base_d      = base_q;
      issued_d    = issued_q + LN_W'(issue_ok);
      received_d  = rcv_next;
      aborted_d   = aborted_q;
      req_valid_d = issue_ok;
      req_addr_d  = req_addr_q;
      req_mdata_d = req_mdata_q;
      if (issue_ok) begin
         req_addr_d  = base_q + t_line_addr'(issued_q);
         req_mdata_d = issued_q[15:0];
      end
      blk_valid_d = rsp_ok && (state_q == S_RD_FETCH);
      blk_idx_d   = blk_idx_q;
      blk_data_d  = blk_data_q;
      if (blk_valid_d) begin
         blk_idx_d  = rd_rsp_mdata;
         blk_data_d = rd_rsp_data;
      end

      case (state_q)
         S_RD_IDLE: begin
            if (start_ok) begin
               num_lines_d = LN_W'(hc_size_to_lines(hc));
               base_d      = hc.addr[47:6];
               issued_d    = '0;
               received_d  = '0;
               aborted_d   = 1'b0;
               state_d     = (num_lines_d == '0) ? S_RD_FINISH : S_RD_FETCH;
            end
         end
         S_RD_FETCH: begin
            // Completion outranks a stop arriving with the final response.
            if (rcv_next == num_lines_q) begin
               state_d = S_RD_FINISH;
            end else if (stop) begin
               state_d   = S_RD_DRAIN;
               aborted_d = 1'b1;
            end
         end
         S_RD_DRAIN: begin
            if (drain_done) state_d = S_RD_FINISH;
         end
         default: state_d = S_RD_IDLE;
      endcase

      done_d = (state_d == S_RD_FINISH);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_RD_IDLE;
         num_lines_q <= '0;
         base_q      <= '0;
         issued_q    <= '0;
         received_q  <= '0;
         aborted_q   <= 1'b0;
         done_q      <= 1'b0;
         req_valid_q <= 1'b0;
         req_addr_q  <= '0;
         req_mdata_q <= '0;
         blk_valid_q <= 1'b0;
         blk_idx_q   <= '0;
         blk_data_q  <= '0;
      end else begin
         state_q     <= state_d;
         num_lines_q <= num_lines_d;
         base_q      <= base_d;
         issued_q    <= issued_d;
         received_q  <= received_d;
         aborted_q   <= aborted_d;
         done_q      <= done_d;
         req_valid_q <= req_valid_d;
         req_addr_q  <= req_addr_d;
         req_mdata_q <= req_mdata_d;
         blk_valid_q <= blk_valid_d;
         blk_idx_q   <= blk_idx_d;
         blk_data_q  <= blk_data_d;
      end
   end

   assign rd_req_valid   = req_valid_q;
   assign rd_req_addr    = req_addr_q;
   assign rd_req_mdata   = req_mdata_q;
   assign blk_valid      = blk_valid_q;
   assign blk_idx        = blk_idx_q;
   assign blk_data       = blk_data_q;
   assign busy           = (state_q != S_RD_IDLE);
   assign done           = done_q;
   assign aborted        = aborted_q;
   assign lines_received = received_q;

endmodule

// File: tb/tb_gaussian_rd_ctrl.sv
// Bench for gaussian_rd_ctrl with a 4-deep in-flight cap; expected lines are
// queued as responses are driven and matched against forwarded blocks.
module tb_gaussian_rd_ctrl;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic         rst_n, start, stop, tx_almfull, rd_rsp_valid;
   logic [63:0]  buf_addr;
   logic [31:0]  buf_size;
   logic [15:0]  rd_rsp_mdata;
   logic [511:0] rd_rsp_data;
   logic         rd_req_valid, blk_valid, busy, done, aborted;
   logic [41:0]  rd_req_addr;
   logic [15:0]  rd_req_mdata, blk_idx;
   logic [511:0] blk_data;
   logic [27:0]  lines_received;

   int checks = 0, failures = 0;
   int req_cnt, blk_cnt, done_cnt, rsp_sent, max_inflight;
   logic [27:0]  done_lines;
   logic         done_abort;
   logic [41:0]  req_addr_obs[$];
   logic [15:0]  req_md_obs[$];
   logic [15:0]  blk_idx_obs[$];
   logic [511:0] blk_dat_obs[$];
   logic [15:0]  exp_idx[$];
   logic [511:0] exp_dat[$];

   gaussian_rd_ctrl #(.MAX_OUTSTANDING(4), .LINES_W(27)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .stop(stop),
      .buf_addr(buf_addr), .buf_size(buf_size), .tx_almfull(tx_almfull),
      .rd_req_valid(rd_req_valid), .rd_req_addr(rd_req_addr), .rd_req_mdata(rd_req_mdata),
      .rd_rsp_valid(rd_rsp_valid), .rd_rsp_mdata(rd_rsp_mdata), .rd_rsp_data(rd_rsp_data),
      .blk_valid(blk_valid), .blk_idx(blk_idx), .blk_data(blk_data),
      .busy(busy), .done(done), .aborted(aborted), .lines_received(lines_received)
   );

   always @(negedge clk) begin
      if (rd_req_valid) begin
         req_addr_obs.push_back(rd_req_addr);
         req_md_obs.push_back(rd_req_mdata);
         req_cnt++;
      end
      if (blk_valid) begin
         blk_idx_obs.push_back(blk_idx);
         blk_dat_obs.push_back(blk_data);
         blk_cnt++;
      end
      if (done) begin
         done_cnt++;
         done_lines = lines_received;
         done_abort = aborted;
      end
      if (req_cnt - rsp_sent > max_inflight) max_inflight = req_cnt - rsp_sent;
   end

   task automatic clear_obs();
      req_addr_obs.delete(); req_md_obs.delete();
      blk_idx_obs.delete(); blk_dat_obs.delete();
      exp_idx.delete(); exp_dat.delete();
      req_cnt = 0; blk_cnt = 0; done_cnt = 0; rsp_sent = 0; max_inflight = 0;
      done_lines = '0; done_abort = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic pulse_start(input logic [63:0] a, input logic [31:0] s, input logic with_stop);
      buf_addr = a; buf_size = s; start = 1'b1; stop = with_stop;
      @(negedge clk);
      start = 1'b0; stop = 1'b0;
   endtask

   task automatic send_rsp(input int idx, input logic fwd, input logic with_stop);
      logic [511:0] d;
      for (int k = 0; k < 16; k++) d[k*32 +: 32] = $urandom();
      rd_rsp_valid = 1'b1; rd_rsp_mdata = 16'(idx); rd_rsp_data = d; stop = with_stop;
      if (fwd) begin
         exp_idx.push_back(16'(idx));
         exp_dat.push_back(d);
      end
      rsp_sent++;
      @(negedge clk);
      rd_rsp_valid = 1'b0; stop = 1'b0;
   endtask

   task automatic wait_reqs(input int n, input int budget);
      for (int c = 0; c < budget && req_cnt < n; c++) @(negedge clk);
   endtask

   task automatic wait_done(input int budget);
      for (int c = 0; c < budget && done_cnt == 0; c++) @(negedge clk);
   endtask

   task automatic test_reset();
      rst_n = 1'b0; start = 0; stop = 0; tx_almfull = 0; rd_rsp_valid = 0;
      buf_addr = '0; buf_size = '0; rd_rsp_mdata = '0; rd_rsp_data = '0;
      clear_obs();
      idle(3);
      checks++;
      if ({rd_req_valid, blk_valid, busy, done, aborted} !== 5'b0) begin
         failures++; $display("FAIL reset_flags got=%b exp=00000", {rd_req_valid, blk_valid, busy, done, aborted});
      end
      checks++;
      if (lines_received !== 28'd0 || rd_req_addr !== 42'd0 || blk_idx !== 16'd0) begin
         failures++; $display("FAIL reset_values lines=%0d addr=%h idx=%0d exp=0", lines_received, rd_req_addr, blk_idx);
      end
      rst_n = 1'b1;
      idle(2);
      checks++;
      if (busy !== 1'b0 || done !== 1'b0) begin
         failures++; $display("FAIL reset_release busy=%b done=%b exp=0", busy, done);
      end
   endtask

   task automatic test_basic();
      logic [15:0] ei, oi; logic [511:0] ed, od;
      clear_obs();
      pulse_start(64'h1000, 32'd256, 1'b0);
      checks++;
      if (busy !== 1'b1 || rd_req_valid !== 1'b0) begin
         failures++; $display("FAIL basic_fetch_entry busy=%b req=%b exp=1,0", busy, rd_req_valid);
      end
      @(negedge clk);
      checks++;
      if (rd_req_valid !== 1'b1 || rd_req_addr !== 42'h40) begin
         failures++; $display("FAIL basic_first_req valid=%b addr=%h exp=1,40", rd_req_valid, rd_req_addr);
      end
      wait_reqs(4, 40); idle(3);
      checks++;
      if (req_cnt !== 4) begin failures++; $display("FAIL basic_req_count got=%0d exp=4", req_cnt); end
      for (int i = 0; i < req_addr_obs.size(); i++) begin
         checks++;
         if (req_addr_obs[i] !== 42'h40 + 42'(i) || req_md_obs[i] !== 16'(i)) begin
            failures++; $display("FAIL basic_req_%0d addr=%h mdata=%0d exp=%h,%0d", i, req_addr_obs[i], req_md_obs[i], 42'h40 + 42'(i), i);
         end
      end
      for (int i = 0; i < 4; i++) send_rsp(i, 1'b1, 1'b0);
      wait_done(20); idle(3);
      checks++;
      if (done_cnt !== 1 || done_lines !== 28'd4 || done_abort !== 1'b0 || busy !== 1'b0) begin
         failures++; $display("FAIL basic_done cnt=%0d lines=%0d abort=%b busy=%b exp=1,4,0,0", done_cnt, done_lines, done_abort, busy);
      end
      checks++;
      if (blk_idx_obs.size() != exp_idx.size()) begin
         failures++; $display("FAIL basic_blk_count got=%0d exp=%0d", blk_idx_obs.size(), exp_idx.size());
      end
      while (exp_idx.size() > 0 && blk_idx_obs.size() > 0) begin
         ei = exp_idx.pop_front(); ed = exp_dat.pop_front();
         oi = blk_idx_obs.pop_front(); od = blk_dat_obs.pop_front();
         checks++;
         if (oi !== ei || od !== ed) begin
            failures++; $display("FAIL basic_blk idx=%0d exp=%0d data_match=%0d", oi, ei, od === ed);
         end
      end
   endtask

   task automatic test_zero_partial();
      clear_obs();
      pulse_start(64'h3000, 32'd0, 1'b0);
      checks++;
      if (done !== 1'b1) begin failures++; $display("FAIL zero_done got=%b exp=1", done); end
      idle(5);
      checks++;
      if (req_cnt !== 0 || done_cnt !== 1 || busy !== 1'b0) begin
         failures++; $display("FAIL zero_run reqs=%0d dones=%0d busy=%b exp=0,1,0", req_cnt, done_cnt, busy);
      end
      clear_obs();
      pulse_start(64'h3000, 32'd65, 1'b0);
      wait_reqs(2, 20); idle(5);
      checks++;
      if (req_cnt !== 2) begin failures++; $display("FAIL partial_req_count got=%0d exp=2", req_cnt); end
      send_rsp(0, 1'b1, 1'b0);
      send_rsp(1, 1'b1, 1'b1);
      wait_done(10); idle(2);
      checks++;
      if (done_cnt !== 1 || done_abort !== 1'b0 || aborted !== 1'b0 || done_lines !== 28'd2 || blk_cnt !== 2) begin
         failures++; $display("FAIL stop_with_last dones=%0d abort=%b/%b lines=%0d blks=%0d exp=1,0/0,2,2", done_cnt, done_abort, aborted, done_lines, blk_cnt);
      end
   endtask

   task automatic test_throttle();
      logic [41:0] base; logic [15:0] ei, oi; logic [511:0] ed, od;
      logic [63:0] a;
      a = 64'h0000_1234_5678_0000;
      base = a[47:6];
      clear_obs();
      pulse_start(a, 32'd1024, 1'b0);
      idle(20);
      checks++;
      if (req_cnt !== 4) begin failures++; $display("FAIL throttle_cap got=%0d exp=4", req_cnt); end
      tx_almfull = 1'b1;
      for (int i = 0; i < 4; i++) send_rsp(i, 1'b1, 1'b0);
      idle(10);
      checks++;
      if (req_cnt !== 4) begin failures++; $display("FAIL throttle_almfull got=%0d exp=4", req_cnt); end
      tx_almfull = 1'b0;
      for (int g = 1; g < 4; g++) begin
         wait_reqs(4 * (g + 1), 30);
         for (int i = 0; i < 4; i++) send_rsp(4 * g + i, 1'b1, 1'b0);
      end
      wait_done(20); idle(2);
      checks++;
      if (req_cnt !== 16 || max_inflight > 4 || done_lines !== 28'd16 || done_cnt !== 1) begin
         failures++; $display("FAIL throttle_run reqs=%0d inflight=%0d lines=%0d dones=%0d exp=16,<=4,16,1", req_cnt, max_inflight, done_lines, done_cnt);
      end
      for (int i = 0; i < req_addr_obs.size(); i++) begin
         checks++;
         if (req_addr_obs[i] !== base + 42'(i) || req_md_obs[i] !== 16'(i)) begin
            failures++; $display("FAIL throttle_req_%0d addr=%h mdata=%0d exp=%h,%0d", i, req_addr_obs[i], req_md_obs[i], base + 42'(i), i);
         end
      end
      checks++;
      if (blk_idx_obs.size() != exp_idx.size()) begin
         failures++; $display("FAIL throttle_blk_count got=%0d exp=%0d", blk_idx_obs.size(), exp_idx.size());
      end
      while (exp_idx.size() > 0 && blk_idx_obs.size() > 0) begin
         ei = exp_idx.pop_front(); ed = exp_dat.pop_front();
         oi = blk_idx_obs.pop_front(); od = blk_dat_obs.pop_front();
         checks++;
         if (oi !== ei || od !== ed) begin
            failures++; $display("FAIL throttle_blk idx=%0d exp=%0d data_match=%0d", oi, ei, od === ed);
         end
      end
   endtask

   task automatic test_out_of_order();
      logic [15:0] ei, oi; logic [511:0] ed, od;
      clear_obs();
      pulse_start(64'h8000, 32'd1024, 1'b0);
      for (int g = 0; g < 4; g++) begin
         wait_reqs(4 * (g + 1), 30);
         if (g == 3) begin
            checks++;
            if (done_cnt !== 0 || busy !== 1'b1) begin
               failures++; $display("FAIL ooo_early_done dones=%0d busy=%b exp=0,1", done_cnt, busy);
            end
         end
         for (int i = 3; i >= 0; i--) send_rsp(4 * g + i, 1'b1, 1'b0);
      end
      wait_done(20); idle(2);
      checks++;
      if (done_cnt !== 1 || max_inflight > 4 || done_lines !== 28'd16 || req_cnt !== 16) begin
         failures++; $display("FAIL ooo_run dones=%0d inflight=%0d lines=%0d reqs=%0d exp=1,<=4,16,16", done_cnt, max_inflight, done_lines, req_cnt);
      end
      checks++;
      if (blk_idx_obs.size() != exp_idx.size()) begin
         failures++; $display("FAIL ooo_blk_count got=%0d exp=%0d", blk_idx_obs.size(), exp_idx.size());
      end
      while (exp_idx.size() > 0 && blk_idx_obs.size() > 0) begin
         ei = exp_idx.pop_front(); ed = exp_dat.pop_front();
         oi = blk_idx_obs.pop_front(); od = blk_dat_obs.pop_front();
         checks++;
         if (oi !== ei || od !== ed) begin
            failures++; $display("FAIL ooo_blk idx=%0d exp=%0d data_match=%0d", oi, ei, od === ed);
         end
      end
   endtask

   task automatic test_abort();
      clear_obs();
      tx_almfull = 1'b1;
      pulse_start(64'h10000, 32'd512, 1'b0);
      tx_almfull = 1'b0;
      idle(3);
      tx_almfull = 1'b1;
      stop = 1'b1;
      @(negedge clk);
      stop = 1'b0;
      tx_almfull = 1'b0;
      idle(6);
      checks++;
      if (req_cnt !== 3 || aborted !== 1'b1 || busy !== 1'b1 || done_cnt !== 0) begin
         failures++; $display("FAIL abort_drain reqs=%0d aborted=%b busy=%b dones=%0d exp=3,1,1,0", req_cnt, aborted, busy, done_cnt);
      end
      send_rsp(0, 1'b0, 1'b0);
      send_rsp(1, 1'b0, 1'b0);
      checks++;
      if (done_cnt !== 0 || busy !== 1'b1) begin
         failures++; $display("FAIL abort_early_done dones=%0d busy=%b exp=0,1", done_cnt, busy);
      end
      send_rsp(2, 1'b0, 1'b0);
      checks++;
      if (done !== 1'b1) begin failures++; $display("FAIL abort_done_timing got=%b exp=1", done); end
      idle(3);
      checks++;
      if (blk_cnt !== 0 || done_cnt !== 1 || done_lines !== 28'd3 || done_abort !== 1'b1 || aborted !== 1'b1) begin
         failures++; $display("FAIL abort_end blks=%0d dones=%0d lines=%0d abort=%b/%b exp=0,1,3,1/1", blk_cnt, done_cnt, done_lines, done_abort, aborted);
      end
      clear_obs();
      pulse_start(64'h20000, 32'd64, 1'b1);
      checks++;
      if (aborted !== 1'b0 || busy !== 1'b1) begin
         failures++; $display("FAIL restart_clear aborted=%b busy=%b exp=0,1", aborted, busy);
      end
      wait_reqs(1, 20);
      send_rsp(0, 1'b1, 1'b0);
      wait_done(10); idle(2);
      checks++;
      if (done_cnt !== 1 || done_abort !== 1'b0 || blk_cnt !== 1 || blk_idx_obs.size() == 0 || blk_idx_obs[0] !== 16'd0 || blk_dat_obs[0] !== exp_dat[0]) begin
         failures++; $display("FAIL restart_run dones=%0d abort=%b blks=%0d exp=1,0,1 with matching line", done_cnt, done_abort, blk_cnt);
      end
   endtask

   task automatic test_busy_and_reset();
      clear_obs();
      pulse_start(64'h40000, 32'd256, 1'b0);
      pulse_start(64'h80000, 32'd256, 1'b0);
      wait_reqs(4, 20); idle(3);
      checks++;
      if (req_cnt !== 4 || req_addr_obs.size() == 0 || req_addr_obs[0] !== 42'h1000) begin
         failures++; $display("FAIL start_busy_reqs reqs=%0d exp=4 from base 1000", req_cnt);
      end
      for (int i = 0; i < 4; i++) send_rsp(i, 1'b1, 1'b0);
      wait_done(10); idle(10);
      checks++;
      if (req_cnt !== 4 || done_cnt !== 1) begin
         failures++; $display("FAIL start_busy_ignored reqs=%0d dones=%0d exp=4,1", req_cnt, done_cnt);
      end
      stop = 1'b1;
      @(negedge clk);
      stop = 1'b0;
      idle(2);
      checks++;
      if (aborted !== 1'b0 || busy !== 1'b0 || done_cnt !== 1) begin
         failures++; $display("FAIL stop_idle aborted=%b busy=%b dones=%0d exp=0,0,1", aborted, busy, done_cnt);
      end
      clear_obs();
      pulse_start(64'h40000, 32'd1024, 1'b0);
      wait_reqs(4, 20);
      send_rsp(0, 1'b1, 1'b0);
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if (busy !== 1'b0 || lines_received !== 28'd0 || rd_req_valid !== 1'b0 || blk_valid !== 1'b0) begin
         failures++; $display("FAIL async_reset busy=%b lines=%0d req=%b blk=%b exp=0", busy, lines_received, rd_req_valid, blk_valid);
      end
      @(negedge clk);
      rst_n = 1'b1;
      idle(1);
      for (int i = 1; i < 4; i++) send_rsp(i, 1'b0, 1'b0);
      idle(3);
      checks++;
      if (blk_cnt !== 1 || lines_received !== 28'd0 || busy !== 1'b0 || done_cnt !== 0) begin
         failures++; $display("FAIL late_rsp_drop blks=%0d lines=%0d busy=%b dones=%0d exp=1,0,0,0", blk_cnt, lines_received, busy, done_cnt);
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_basic();
      test_zero_partial();
      test_throttle();
      test_out_of_order();
      test_abort();
      test_busy_and_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
